demux_1_4: RTL and testbench
============================

# demux_1_4

Registered 1-to-4 demultiplexer: the write-side counterpart of the 4:1 selector mux. One input word is routed by `selector` into one of four single-entry output buffers (A, B, C, D). Each buffer has its own valid/ready handshake. The block feeds channelized consumers, and its outputs can be looped back into the 4:1 mux for round-trip checks.

## Interface
Parameters:
- `WIDTH`, 4: data width of `din` and each channel output.
- `CNT_W`, 8: width of the accepted-word counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `selector`, input, 2: destination channel (0=A, 1=B, 2=C, 3=D). Sampled with `in_valid`.
- `din`, input, `WIDTH`: input data word.
- `in_valid`, input, 1: `din`/`selector` valid.
- `in_ready`, output, 1: the selected channel can accept this cycle.
- `A`, `B`, `C`, `D`, output, `WIDTH` each: per-channel buffered data.
- `out_valid`, output, 4: per-channel valid. Bit 0 is A, bit 3 is D.
- `out_ready`, input, 4: per-channel consumer ready.
- `accepted`, output, `CNT_W`: count of accepted input words, wraps.

## Operation
- Each channel slot is either EMPTY or FULL; `out_valid[i]` is 1 iff slot i is FULL.
- `in_ready = !out_valid[selector] || out_ready[selector]`. This is combinational from `selector` and that slot's state only. Other channels never stall the input.
- Input transfer happens when `in_valid && in_ready`. The selected slot loads `din` and becomes FULL.
- Output transfer on channel i happens when `out_valid[i] && out_ready[i]`.
- Slot i transitions:
  - EMPTY + load goes to FULL.
  - FULL + drain, no load, goes to EMPTY.
  - FULL + drain + load in the same cycle stays FULL and takes the new data.
  - FULL, no drain: holds; data is stable.
- Unselected channels keep their data and state. Outputs of EMPTY slots keep their last value; consumers must qualify data with `out_valid`.
- `accepted` increments by 1 per input transfer and wraps from 2^CNT_W−1 to 0.
- Words are never dropped or duplicated. Per-channel order is preserved trivially, since each slot holds one entry.
- `in_valid` low: no slot loads, regardless of `selector`.

## Timing
- Reset values: `A`=`B`=`C`=`D`=0, `out_valid`=4'b0000, `accepted`=0. `in_ready` is then 1 for any `selector`.
- Reset is asynchronous. Asserting it mid-operation clears all slots immediately; buffered words are discarded.
- Latency: a word accepted at edge N appears on the channel output with `out_valid` high after edge N, i.e. in the next cycle.
- Throughput: one word per cycle into the same channel while its `out_ready` is held high.
- `out_valid[i]` never deasserts without a drain or a reset.
- A, B, C, D, `out_valid` and `accepted` are flop outputs. `in_ready` is the only combinational output.

## Structure
- Package `demux_pkg`:
  - `localparam N_CH = 4`
  - `typedef logic [1:0] sel_t`
  - `typedef enum logic {EMPTY, FULL} slot_state_t`
- Sub-module `demux_slot`: one-entry buffer with load/drain, state, and a data register. It is instantiated four times. The top level holds select decode, the `in_ready` mux, and the counter.

## Test plan
1. Reset: assert `rst` asynchronously between edges. Outputs go to 0 at once, `out_valid`=0000, `accepted`=0, and `in_ready`=1 for `selector`=0..3.
2. Routing: with `out_ready`=1111, send A=12 (sel 0), 11 (sel 1), 9 (sel 2), 14 (sel 3) on consecutive cycles.
   - Each word appears one cycle later on the matching output, with that `out_valid` bit pulsing for one cycle.
   - `accepted`=4 at the end.
3. Backpressure: `out_ready`=0000, load 11 into B.
   - Next cycle with `selector`=1: `in_ready`=0, and B holds 11.
   - With `selector`=2: `in_ready`=1, C loads.
4. Simultaneous load and drain: B FULL with 11, `out_ready[1]`=1, input 5 on sel 1.
   - The same edge drains 11 and loads 5.
   - `out_valid[1]` stays 1 and B=5. `accepted` increments by 1.
5. Selector sweep: data 12/11/9/14 held, `selector` incremented 8 times from 0 with `out_ready`=1111.
   - The selector wraps 3 to 0, and each channel receives exactly two words.
   - `accepted` increments by exactly 8 over the sweep.
6. Counter wrap and mid-operation reset:
   - 256 transfers return `accepted` to 0.
   - Then fill all four slots and pulse `rst`. `out_valid`=0000 immediately, and no stale word reappears after reset release.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types for the registered 1-to-4 demultiplexer.
package demux_pkg;
   localparam int N_CH = 4;

   typedef logic [1:0] sel_t;

   typedef enum logic {EMPTY, FULL} slot_state_t;
endpackage

// File: rtl/demux_slot.sv
// Single-entry output buffer: one data register plus EMPTY/FULL state with a
// valid/ready drain side. Load is only asserted by the top when the slot can take it.
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             ready,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             valid
);

   slot_state_t state;
   slot_state_t state_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
         dout  <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            dout <= din;
         end
      end
   end

   // A load while FULL always coincides with a drain, so the slot stays FULL.
   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (load) state_next = FULL;
         FULL:    if (ready && !load) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   assign valid = (state == FULL);

endmodule

// File: rtl/demux_1_4.sv
// Registered 1-to-4 demultiplexer: routes din into one of four single-entry
// channel buffers chosen by selector, and counts accepted input words.
module demux_1_4
   import demux_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       selector,
   input  logic [WIDTH-1:0] din,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] D,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [CNT_W-1:0] accepted
);

   sel_t             sel;
   logic             xfer;
   logic [N_CH-1:0]  load;
   logic [WIDTH-1:0] slot_data [N_CH];

   assign sel = sel_t'(selector);

   // Only the addressed slot can stall the input.
   assign in_ready = !out_valid[sel] || out_ready[sel];
   assign xfer     = in_valid && in_ready;

   for (genvar i = 0; i < N_CH; i++) begin : g_slot
      assign load[i] = xfer && (sel == sel_t'(i));

      demux_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk   (clk),
         .rst   (rst),
         .load  (load[i]),
         .ready (out_ready[i]),
         .din   (din),
         .dout  (slot_data[i]),
         .valid (out_valid[i])
      );
   end

   assign A = slot_data[0];
   assign B = slot_data[1];
   assign C = slot_data[2];
   assign D = slot_data[3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accepted <= '0;
      end else if (xfer) begin
         accepted <= accepted + 1'b1;
      end
   end

endmodule

// File: tb/tb_demux_1_4.sv
// Scoreboarded bench for demux_1_4: stimulus pushes expected words per channel,
// a negedge monitor pops and compares them whenever a channel drains.
module tb_demux_1_4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] selector = '0;
   logic [3:0] din = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] A, B, C, D;
   logic [3:0] out_valid;
   logic [3:0] out_ready = '0;
   logic [7:0] accepted;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [3:0] q [4][$];
   int         drained [4] = '{0, 0, 0, 0};
   logic [7:0] acc_exp = '0;

   demux_1_4 #(.WIDTH(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .selector  (selector),
      .din       (din),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .accepted  (accepted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [3:0] ch_data(input int i);
      case (i)
         0:       return A;
         1:       return B;
         2:       return C;
         default: return D;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               if (q[i].size() == 0) begin
                  chk($sformatf("ch%0d_unexpected_valid", i), 32'(out_valid[i]), 32'd0);
               end else begin
                  chk($sformatf("ch%0d_data", i), 32'(ch_data(i)), 32'(q[i].pop_front()));
                  drained[i]++;
               end
            end
         end
      end
   end

   // Inputs change 1 time unit after the rising edge; returns 1 time unit after the next one.
   task automatic send(input logic [1:0] s, input logic [3:0] d, output logic ok);
      selector = s;
      din      = d;
      in_valid = 1'b1;
      #1;
      ok = in_ready;
      if (ok) begin
         q[s].push_back(d);
         acc_exp++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic flush_model();
      for (int i = 0; i < 4; i++) q[i].delete();
      acc_exp = '0;
   endtask

   logic [3:0] tbl [4] = '{4'd12, 4'd11, 4'd9, 4'd14};
   logic       ok;
   logic [1:0] s;
   int         base [4];

   initial begin
      // Reset and reset values
      idle(2);
      #2;
      rst = 1'b0;
      idle(1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_accepted", 32'(accepted), 32'd0);
      chk("rst_data", {16'd0, A, B, C, D}, 32'd0);

      // Load something, then assert reset between edges and look immediately
      out_ready = 4'b0000;
      send(2'd3, 4'd7, ok);
      chk("pre_rst_D", 32'(D), 32'd7);
      #2;
      rst = 1'b1;
      flush_model();
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_D", 32'(D), 32'd0);
      chk("async_rst_acc", 32'(accepted), 32'd0);
      for (int i = 0; i < 4; i++) begin
         selector = 2'(i);
         #1;
         chk($sformatf("rst_in_ready_sel%0d", i), 32'(in_ready), 32'd1);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);

      // Routing with all consumers ready
      out_ready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         send(2'(i), tbl[i], ok);
         chk($sformatf("route_ok%0d", i), 32'(ok), 32'd1);
         chk($sformatf("route_valid%0d", i), 32'(out_valid), 32'(4'b0001 << i));
         chk($sformatf("route_data%0d", i), 32'(ch_data(i)), 32'(tbl[i]));
      end
      idle(1);
      chk("route_valid_clear", 32'(out_valid), 32'd0);
      chk("route_accepted", 32'(accepted), 32'd4);

      // Backpressure on B, C still free
      out_ready = 4'b0000;
      send(2'd1, 4'd11, ok);
      chk("bp_load_B", 32'(ok), 32'd1);
      send(2'd1, 4'd7, ok);
      chk("bp_in_ready_B", 32'(ok), 32'd0);
      chk("bp_hold_B", 32'(B), 32'd11);
      chk("bp_valid_B", 32'(out_valid[1]), 32'd1);
      send(2'd2, 4'd9, ok);
      chk("bp_in_ready_C", 32'(ok), 32'd1);
      chk("bp_load_C", 32'(C), 32'd9);
      chk("bp_valid", 32'(out_valid), 32'b0110);
      chk("bp_accepted", 32'(accepted), 32'(acc_exp));

      // Drain and load B on the same edge
      out_ready = 4'b0010;
      send(2'd1, 4'd5, ok);
      chk("ld_dr_ok", 32'(ok), 32'd1);
      chk("ld_dr_valid", 32'(out_valid[1]), 32'd1);
      chk("ld_dr_B", 32'(B), 32'd5);
      chk("ld_dr_accepted", 32'(accepted), 32'(acc_exp));
      out_ready = 4'b1111;
      idle(2);
      chk("ld_dr_empty", 32'(out_valid), 32'd0);

      // Selector sweep with wrap
      for (int i = 0; i < 4; i++) base[i] = drained[i];
      s = 2'd0;
      for (int k = 0; k < 8; k++) begin
         send(s, tbl[s], ok);
         s++;
      end
      idle(1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("sweep_count%0d", i), 32'(drained[i] - base[i]), 32'd2);
      chk("sweep_accepted", 32'(accepted), 32'(acc_exp));

      // Counter wrap from a clean reset
      rst = 1'b1;
      flush_model();
      #1;
      rst = 1'b0;
      idle(1);
      for (int k = 0; k < 256; k++) send(2'(k), 4'(k * 3), ok);
      idle(1);
      chk("wrap_accepted", 32'(accepted), 32'd0);

      // Fill all slots, reset mid-operation, confirm nothing stale returns
      out_ready = 4'b0000;
      for (int i = 0; i < 4; i++) send(2'(i), 4'(i + 1), ok);
      chk("fill_valid", 32'(out_valid), 32'b1111);
      #2;
      rst = 1'b1;
      flush_model();
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 4'b1111;
      idle(3);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_accepted", 32'(accepted), 32'd0);

      for (int i = 0; i < 4; i++)
         chk($sformatf("q%0d_empty", i), 32'(q[i].size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
